// File: rtl/fbs_pkg.sv
// Shared types and the bank base-address helper for the triple-buffer frame bank scheduler.
package fbs_pkg;

    typedef logic [1:0] bank_t;

    typedef enum logic [1:0] {
        INIT,
        IDLE,
        SETUP,
        LOAD
    } seq_state_t;

    localparam int unsigned BASE_W = 32;

    // Callers truncate the result to their own address width.
    function automatic logic [BASE_W-1:0] bank_base(input bank_t bank,
                                                    input int unsigned base,
                                                    input int unsigned words);
        return base + 32'(bank) * words;
    endfunction

endpackage

// File: rtl/fbs_edge_sync.sv
// Two-flop synchronizer followed by a registered falling-edge detector (one-cycle pulse).
module fbs_edge_sync (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic async_i,
    output logic fall_o
);

    logic [2:0] sync_q;
    logic       fall_q;

    // sync_q[1] is the synchronized level; sync_q[2] is its previous value.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync_q <= '0;
            fall_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[1:0], async_i};
            fall_q <= sync_q[2] & ~sync_q[1];
        end
    end

    assign fall_o = fall_q;

endmodule

// File: rtl/frame_bank_scheduler.sv
// Triple-buffer bank scheduler: rotates write/read/ready frame banks on camera and VGA
// vertical-sync falls and sequences the SDRAM controller pointer reloads.
module frame_bank_scheduler
    import fbs_pkg::*;
#(
    parameter int unsigned ADDR_W      = 23,
    parameter int unsigned BASE_ADDR   = 0,
    parameter int unsigned FRAME_WORDS = 307200,
    parameter int unsigned LOAD_CYCLES = 4
) (
    input  logic              iCLK,
    input  logic              iRST_N,
    input  logic              iWR_VS,
    input  logic              iRD_VS,
    input  logic              iFREEZE,
    output logic [ADDR_W-1:0] oWR_ADDR,
    output logic              oWR_LOAD,
    output logic [ADDR_W-1:0] oRD_ADDR,
    output logic              oRD_LOAD,
    output logic [1:0]        oWR_BANK,
    output logic [1:0]        oRD_BANK,
    output logic              oFRESH,
    output logic [7:0]        oDROP_CNT
);

    if (64'(BASE_ADDR) + 64'(3) * 64'(FRAME_WORDS) > (64'(1) << ADDR_W)) begin : g_addr_check
        $error("frame_bank_scheduler: three frame banks do not fit in ADDR_W address bits");
    end

    localparam int unsigned          CNT_W    = (LOAD_CYCLES > 1) ? $clog2(LOAD_CYCLES) : 1;
    localparam logic [CNT_W-1:0]     CNT_LAST = CNT_W'(LOAD_CYCLES - 1);

    logic [1:0]       ev_fall;
    logic             wr_ev, rd_ev;
    seq_state_t       seq_q [2];
    logic [CNT_W-1:0] cnt_q [2];
    logic [1:0]       load_q;

    bank_t            w_q, r_q, f_q, w_d, r_d, f_d, tmp_bank;
    logic             fresh_q, fresh_d;
    logic [7:0]       drop_q, drop_d;
    logic [ADDR_W-1:0] wr_addr_q, rd_addr_q;

    fbs_edge_sync u_wr_sync (.clk_i(iCLK), .rst_ni(iRST_N), .async_i(iWR_VS), .fall_o(ev_fall[0]));
    fbs_edge_sync u_rd_sync (.clk_i(iCLK), .rst_ni(iRST_N), .async_i(iRD_VS), .fall_o(ev_fall[1]));

    // A port only accepts an event while its sequencer is idle.
    assign wr_ev = ev_fall[0] && (seq_q[0] == IDLE);
    assign rd_ev = ev_fall[1] && (seq_q[1] == IDLE);

    // Sequencer index 0 serves the write port, index 1 the read port.
    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            for (int i = 0; i < 2; i++) begin
                seq_q[i] <= INIT;
                cnt_q[i] <= '0;
            end
            load_q <= '0;
        end else begin
            for (int i = 0; i < 2; i++) begin
                case (seq_q[i])
                    INIT:  seq_q[i] <= SETUP;
                    IDLE:  if (ev_fall[i]) seq_q[i] <= SETUP;
                    SETUP: begin
                        seq_q[i]  <= LOAD;
                        load_q[i] <= 1'b1;
                        cnt_q[i]  <= '0;
                    end
                    LOAD: begin
                        if (cnt_q[i] == CNT_LAST) begin
                            seq_q[i]  <= IDLE;
                            load_q[i] <= 1'b0;
                        end else begin
                            cnt_q[i] <= cnt_q[i] + CNT_W'(1);
                        end
                    end
                    default: seq_q[i] <= INIT;
                endcase
            end
        end
    end

    // Write swap is applied first; a same-cycle read swap then sees its result.
    always_comb begin
        w_d      = w_q;
        r_d      = r_q;
        f_d      = f_q;
        fresh_d  = fresh_q;
        drop_d   = drop_q;
        tmp_bank = r_q;
        if (wr_ev) begin
            w_d     = f_q;
            f_d     = w_q;
            fresh_d = 1'b1;
            if (fresh_q && (drop_q != 8'hFF)) drop_d = drop_q + 8'd1;
        end
        if (rd_ev && fresh_d && !iFREEZE) begin
            tmp_bank = r_d;
            r_d      = f_d;
            f_d      = tmp_bank;
            fresh_d  = 1'b0;
        end
    end

    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            w_q       <= 2'd0;
            r_q       <= 2'd1;
            f_q       <= 2'd2;
            fresh_q   <= 1'b0;
            drop_q    <= '0;
            wr_addr_q <= ADDR_W'(bank_base(2'd0, BASE_ADDR, FRAME_WORDS));
            rd_addr_q <= ADDR_W'(bank_base(2'd1, BASE_ADDR, FRAME_WORDS));
        end else begin
            w_q       <= w_d;
            r_q       <= r_d;
            f_q       <= f_d;
            fresh_q   <= fresh_d;
            drop_q    <= drop_d;
            wr_addr_q <= ADDR_W'(bank_base(w_d, BASE_ADDR, FRAME_WORDS));
            rd_addr_q <= ADDR_W'(bank_base(r_d, BASE_ADDR, FRAME_WORDS));
        end
    end

    assign oWR_ADDR  = wr_addr_q;
    assign oRD_ADDR  = rd_addr_q;
    assign oWR_LOAD  = load_q[0];
    assign oRD_LOAD  = load_q[1];
    assign oWR_BANK  = w_q;
    assign oRD_BANK  = r_q;
    assign oFRESH    = fresh_q;
    assign oDROP_CNT = drop_q;

endmodule

// File: tb/tb_frame_bank_scheduler.sv
// Self-checking bench for frame_bank_scheduler: directed scenarios plus randomized
// event sequences compared against a bank-rotation reference model.
module tb_frame_bank_scheduler;

    localparam int FW = 307200;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        wr_vs = 1'b0;
    logic        rd_vs = 1'b1;
    logic        freeze = 1'b0;
    logic [22:0] wr_addr, rd_addr;
    logic        wr_load, rd_load;
    logic [1:0]  wr_bank, rd_bank;
    logic        fresh;
    logic [7:0]  drop_cnt;

    int checks = 0;
    int errors = 0;
    int wr_lc = 0;
    int rd_lc = 0;

    // Reference model state: which physical bank plays each role.
    int mw, mr, mf, mdrop;
    bit mfresh;

    frame_bank_scheduler dut (
        .iCLK(clk), .iRST_N(rst_n), .iWR_VS(wr_vs), .iRD_VS(rd_vs), .iFREEZE(freeze),
        .oWR_ADDR(wr_addr), .oWR_LOAD(wr_load), .oRD_ADDR(rd_addr), .oRD_LOAD(rd_load),
        .oWR_BANK(wr_bank), .oRD_BANK(rd_bank), .oFRESH(fresh), .oDROP_CNT(drop_cnt)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (wr_load) wr_lc++;
        if (rd_load) rd_lc++;
    end

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation did not complete, got timeout required finish");
        $fatal(1, "watchdog expired");
    end

    task automatic model_reset();
        mw = 0; mr = 1; mf = 2; mfresh = 0; mdrop = 0;
    endtask

    task automatic model_event(input bit w, input bit r, input bit frz);
        int t;
        if (w) begin
            if (mfresh) mdrop = (mdrop < 255) ? mdrop + 1 : 255;
            t = mw; mw = mf; mf = t;
            mfresh = 1;
        end
        if (r && mfresh && !frz) begin
            t = mr; mr = mf; mf = t;
            mfresh = 0;
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        wr_vs = 1'b0;
        rd_vs = 1'b1;
        freeze = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (10) @(negedge clk);
        model_reset();
    endtask

    // Drives one camera and/or VGA VS fall (simultaneous when both) and waits for the sequencers.
    task automatic pulse_vs(input bit w, input bit r, output int wn, output int rn);
        int w0, r0;
        w0 = wr_lc; r0 = rd_lc;
        @(negedge clk);
        if (w) wr_vs = 1'b1;
        repeat (4) @(negedge clk);
        if (w) wr_vs = 1'b0;
        if (r) rd_vs = 1'b0;
        repeat (6) @(negedge clk);
        rd_vs = 1'b1;
        repeat (8) @(negedge clk);
        wn = wr_lc - w0;
        rn = rd_lc - r0;
    endtask

    task automatic test_reset();
        bit exp_l;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        checks++; if (wr_addr !== 23'd0) begin errors++; $display("FAIL rst_wr_addr: got %0d expected 0", wr_addr); end
        checks++; if (rd_addr !== 23'(FW)) begin errors++; $display("FAIL rst_rd_addr: got %0d expected %0d", rd_addr, FW); end
        checks++; if (fresh !== 1'b0 || drop_cnt !== 8'd0) begin errors++; $display("FAIL rst_fresh_drop: got %0b/%0d expected 0/0", fresh, drop_cnt); end
        checks++; if (wr_bank !== 2'd0 || rd_bank !== 2'd1) begin errors++; $display("FAIL rst_banks: got %0d/%0d expected 0/1", wr_bank, rd_bank); end
        checks++; if (wr_load !== 1'b0 || rd_load !== 1'b0) begin errors++; $display("FAIL rst_load: got %0b/%0b expected 0/0", wr_load, rd_load); end
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            @(negedge clk);
            exp_l = (i >= 2 && i <= 5);
            checks++;
            if (wr_load !== exp_l || rd_load !== exp_l) begin
                errors++;
                $display("FAIL init_load_cycle%0d: got wr=%0b rd=%0b expected %0b", i, wr_load, rd_load, exp_l);
            end
        end
        repeat (4) @(negedge clk);
    endtask

    task automatic test_basic_swap();
        int wn, rn;
        do_reset();
        pulse_vs(1, 0, wn, rn);
        checks++; if (wr_addr !== 23'(2*FW)) begin errors++; $display("FAIL wr_swap_addr: got %0d expected %0d", wr_addr, 2*FW); end
        checks++; if (fresh !== 1'b1) begin errors++; $display("FAIL wr_swap_fresh: got %0b expected 1", fresh); end
        checks++; if (wn != 4 || rn != 0) begin errors++; $display("FAIL wr_swap_loads: got wr=%0d rd=%0d expected 4/0", wn, rn); end
        pulse_vs(0, 1, wn, rn);
        checks++; if (rd_addr !== 23'd0) begin errors++; $display("FAIL rd_swap_addr: got %0d expected 0", rd_addr); end
        checks++; if (fresh !== 1'b0) begin errors++; $display("FAIL rd_swap_fresh: got %0b expected 0", fresh); end
        checks++; if (wn != 0 || rn != 4) begin errors++; $display("FAIL rd_swap_loads: got wr=%0d rd=%0d expected 0/4", wn, rn); end
    endtask

    task automatic test_drop();
        int wn, rn;
        do_reset();
        pulse_vs(1, 0, wn, rn);
        pulse_vs(1, 0, wn, rn);
        checks++; if (wr_addr !== 23'd0) begin errors++; $display("FAIL drop_wr_addr: got %0d expected 0", wr_addr); end
        checks++; if (drop_cnt !== 8'd1) begin errors++; $display("FAIL drop_cnt: got %0d expected 1", drop_cnt); end
        pulse_vs(0, 1, wn, rn);
        checks++; if (rd_addr !== 23'(2*FW)) begin errors++; $display("FAIL drop_rd_addr: got %0d expected %0d", rd_addr, 2*FW); end
    endtask

    task automatic test_simultaneous();
        int wn, rn;
        do_reset();
        pulse_vs(1, 1, wn, rn);
        checks++; if (rd_bank !== 2'd0 || wr_bank !== 2'd2) begin errors++; $display("FAIL simul_banks: got rd=%0d wr=%0d expected 0/2", rd_bank, wr_bank); end
        checks++; if (fresh !== 1'b0 || drop_cnt !== 8'd0) begin errors++; $display("FAIL simul_fresh_drop: got %0b/%0d expected 0/0", fresh, drop_cnt); end
        checks++; if (wn != 4 || rn != 4) begin errors++; $display("FAIL simul_loads: got wr=%0d rd=%0d expected 4/4", wn, rn); end
    endtask

    task automatic test_freeze();
        int wn, rn, rtot;
        do_reset();
        freeze = 1'b1;
        rtot = 0;
        for (int k = 0; k < 300; k++) begin
            pulse_vs(1, 0, wn, rn);
            rtot += rn;
            pulse_vs(0, 1, wn, rn);
            rtot += rn;
        end
        checks++; if (rd_addr !== 23'(FW)) begin errors++; $display("FAIL freeze_rd_addr: got %0d expected %0d", rd_addr, FW); end
        checks++; if (rtot != 1200) begin errors++; $display("FAIL freeze_rd_loads: got %0d expected 1200", rtot); end
        checks++; if (drop_cnt !== 8'd255) begin errors++; $display("FAIL freeze_drop_sat: got %0d expected 255", drop_cnt); end
        checks++; if (fresh !== 1'b1) begin errors++; $display("FAIL freeze_fresh: got %0b expected 1", fresh); end
        freeze = 1'b0;
    endtask

    task automatic test_busy_and_reset();
        int w0, budget;
        do_reset();
        w0 = wr_lc;
        @(negedge clk); wr_vs = 1'b1;
        repeat (4) @(negedge clk); wr_vs = 1'b0;
        @(negedge clk); wr_vs = 1'b1;
        @(negedge clk); wr_vs = 1'b0;
        repeat (15) @(negedge clk);
        checks++; if (wr_bank !== 2'd2) begin errors++; $display("FAIL busy_wr_bank: got %0d expected 2", wr_bank); end
        checks++; if (fresh !== 1'b1 || drop_cnt !== 8'd0) begin errors++; $display("FAIL busy_fresh_drop: got %0b/%0d expected 1/0", fresh, drop_cnt); end
        checks++; if (wr_lc - w0 != 4) begin errors++; $display("FAIL busy_wr_loads: got %0d expected 4", wr_lc - w0); end
        wr_vs = 1'b1;
        repeat (4) @(negedge clk); wr_vs = 1'b0;
        budget = 0;
        while (wr_load !== 1'b1 && budget < 20) begin
            @(negedge clk);
            budget++;
        end
        checks++; if (wr_load !== 1'b1) begin errors++; $display("FAIL midload_wait: got load=%0b expected 1 within 20 cycles", wr_load); end
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        checks++; if (wr_load !== 1'b0 || rd_load !== 1'b0) begin errors++; $display("FAIL midload_rst_load: got %0b/%0b expected 0/0", wr_load, rd_load); end
        checks++; if (wr_addr !== 23'd0 || rd_addr !== 23'(FW)) begin errors++; $display("FAIL midload_rst_addr: got %0d/%0d expected 0/%0d", wr_addr, rd_addr, FW); end
        checks++; if (wr_bank !== 2'd0 || fresh !== 1'b0) begin errors++; $display("FAIL midload_rst_state: got bank=%0d fresh=%0b expected 0/0", wr_bank, fresh); end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (10) @(negedge clk);
    endtask

    task automatic test_random();
        int wn, rn;
        bit w, r, frz;
        do_reset();
        for (int k = 0; k < 40; k++) begin
            w = 1'($urandom_range(0, 1));
            r = 1'($urandom_range(0, 1));
            frz = ($urandom_range(0, 3) == 0);
            if (!w && !r) w = 1'b1;
            freeze = frz;
            pulse_vs(w, r, wn, rn);
            model_event(w, r, frz);
            checks++;
            if (wr_bank !== 2'(mw) || rd_bank !== 2'(mr) || fresh !== mfresh || drop_cnt !== 8'(mdrop)) begin
                errors++;
                $display("FAIL rand%0d_state: got w=%0d r=%0d fresh=%0b drop=%0d expected w=%0d r=%0d fresh=%0b drop=%0d",
                         k, wr_bank, rd_bank, fresh, drop_cnt, mw, mr, mfresh, mdrop);
            end
            checks++;
            if (wr_addr !== 23'(mw * FW) || rd_addr !== 23'(mr * FW)) begin
                errors++;
                $display("FAIL rand%0d_addr: got %0d/%0d expected %0d/%0d", k, wr_addr, rd_addr, mw * FW, mr * FW);
            end
            checks++;
            if (wn != (w ? 4 : 0) || rn != (r ? 4 : 0)) begin
                errors++;
                $display("FAIL rand%0d_loads: got wr=%0d rd=%0d expected %0d/%0d", k, wn, rn, w ? 4 : 0, r ? 4 : 0);
            end
        end
        freeze = 1'b0;
    endtask

    initial begin
        test_reset();
        test_basic_swap();
        test_drop();
        test_simultaneous();
        test_busy_and_reset();
        test_random();
        test_freeze();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
